// File: rtl/dunc16_timing.sv
// Major-state (FETCH/DEFER/EXECUTE) and T0..T3 phase generator for the dunc16 core.
// Run/halt/step control; halts are deferred to the instruction boundary so a cycle never stops midway.
module dunc16_timing #(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic RUN,
    input  logic HALT,
    input  logic STEP,
    input  logic MEMREF,
    input  logic IND,
    output logic FETCH,
    output logic DEFER,
    output logic EXECUTE,
    output logic T0,
    output logic T1,
    output logic T2,
    output logic T3,
    output logic TP,
    output logic RUNNING
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        MAJ_FETCH = 2'd0,
        MAJ_DEFER = 2'd1,
        MAJ_EXEC  = 2'd2
    } major_t;

    major_t        major_q, major_d, major_nxt;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          running_q, running_d;
    logic          halt_pend_q, halt_pend_d;
    logic          tp;
    logic          pend_now;

    assign tp = running_q && (cnt_q == CNT_LAST);

    // A halt request seen on the boundary edge itself still stops at that boundary.
    assign pend_now = halt_pend_q || HALT || STEP;

    always_comb begin
        major_nxt = MAJ_FETCH;
        case (major_q)
            MAJ_FETCH: begin
                if (MEMREF) major_nxt = IND ? MAJ_DEFER : MAJ_EXEC;
                else        major_nxt = MAJ_FETCH;
            end
            MAJ_DEFER: major_nxt = MAJ_EXEC;
            default:   major_nxt = MAJ_FETCH;
        endcase
    end

    always_comb begin
        running_d   = running_q;
        major_d     = major_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        if (!running_q) begin
            cnt_d   = '0;
            phase_d = 2'd0;
            if (HALT) begin
                halt_pend_d = 1'b0;
            end else if (RUN || STEP) begin
                running_d   = 1'b1;
                halt_pend_d = STEP;
            end
        end else begin
            halt_pend_d = pend_now;
            if (tp) begin
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    major_d = major_nxt;
                    if (major_nxt == MAJ_FETCH && pend_now) begin
                        running_d   = 1'b0;
                        halt_pend_d = 1'b0;
                        phase_d     = 2'd0;
                    end
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            running_q   <= 1'b0;
            major_q     <= MAJ_FETCH;
            phase_q     <= 2'd0;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            running_q   <= running_d;
            major_q     <= major_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign FETCH   = (major_q == MAJ_FETCH);
    assign DEFER   = (major_q == MAJ_DEFER);
    assign EXECUTE = (major_q == MAJ_EXEC);
    assign T0      = running_q && (phase_q == 2'd0);
    assign T1      = running_q && (phase_q == 2'd1);
    assign T2      = running_q && (phase_q == 2'd2);
    assign T3      = running_q && (phase_q == 2'd3);
    assign TP      = tp;
    assign RUNNING = running_q;

endmodule

// File: tb/tb_dunc16_timing.sv
// Directed checks of dunc16_timing at PRESCALE=1 and PRESCALE=3; both instances share stimulus.
module tb_dunc16_timing;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic halt = 1'b0;
    logic step = 1'b0;
    logic memref = 1'b0;
    logic ind = 1'b0;

    logic a_fetch, a_defer, a_exec, a_t0, a_t1, a_t2, a_t3, a_tp, a_run;
    logic b_fetch, b_defer, b_exec, b_t0, b_t1, b_t2, b_t3, b_tp, b_run;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dunc16_timing #(.PRESCALE(1)) dut1 (
        .CLK(clk), .RESET(reset), .RUN(run), .HALT(halt), .STEP(step),
        .MEMREF(memref), .IND(ind),
        .FETCH(a_fetch), .DEFER(a_defer), .EXECUTE(a_exec),
        .T0(a_t0), .T1(a_t1), .T2(a_t2), .T3(a_t3), .TP(a_tp), .RUNNING(a_run)
    );

    dunc16_timing #(.PRESCALE(3)) dut3 (
        .CLK(clk), .RESET(reset), .RUN(run), .HALT(halt), .STEP(step),
        .MEMREF(memref), .IND(ind),
        .FETCH(b_fetch), .DEFER(b_defer), .EXECUTE(b_exec),
        .T0(b_t0), .T1(b_t1), .T2(b_t2), .T3(b_t3), .TP(b_tp), .RUNNING(b_run)
    );

    // {RUNNING, FETCH, DEFER, EXECUTE, T0, T1, T2, T3, TP}
    logic [8:0] o1, o3;
    assign o1 = {a_run, a_fetch, a_defer, a_exec, a_t0, a_t1, a_t2, a_t3, a_tp};
    assign o3 = {b_run, b_fetch, b_defer, b_exec, b_t0, b_t1, b_t2, b_t3, b_tp};

    localparam logic [8:0] HALTED = 9'b0_100_0000_0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (o1 !== HALTED) begin
            bad++;
            $display("FAIL reset_p1 got=%b want=%b", o1, HALTED);
        end
        total++;
        if (o3 !== HALTED) begin
            bad++;
            $display("FAIL reset_p3 got=%b want=%b", o3, HALTED);
        end
        tick();
        total++;
        if (o1 !== HALTED) begin
            bad++;
            $display("FAIL idle_after_reset got=%b want=%b", o1, HALTED);
        end
    endtask

    task automatic test_run_p1();
        logic [8:0] exp;
        do_reset();
        memref = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int c = 0; c < 12; c++) begin
            exp = {1'b1, 3'b100, 4'b1000 >> (c % 4), 1'b1};
            total++;
            if (o1 !== exp) begin
                bad++;
                $display("FAIL run_p1 c=%0d got=%b want=%b", c, o1, exp);
            end
            tick();
        end
    endtask

    task automatic test_prescale3_defer();
        logic [8:0] exp;
        do_reset();
        memref = 1'b1; ind = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int c = 0; c < 40; c++) begin
            exp = {1'b1, 3'b100 >> ((c / 12) % 3), 4'b1000 >> ((c % 12) / 3), (c % 3) == 2};
            total++;
            if (o3 !== exp) begin
                bad++;
                $display("FAIL p3_defer c=%0d got=%b want=%b", c, o3, exp);
            end
            tick();
        end
    endtask

    task automatic test_step();
        logic [8:0] exp;
        do_reset();
        memref = 1'b1; ind = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int c = 0; c < 8; c++) begin
            exp = {1'b1, (c < 4) ? 3'b100 : 3'b001, 4'b1000 >> (c % 4), 1'b1};
            total++;
            if (o1 !== exp) begin
                bad++;
                $display("FAIL step c=%0d got=%b want=%b", c, o1, exp);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (o1 !== HALTED) begin
                bad++;
                $display("FAIL step_halted c=%0d got=%b want=%b", c, o1, HALTED);
            end
            tick();
        end
    endtask

    task automatic test_halt_in_defer();
        logic [8:0] exp;
        do_reset();
        memref = 1'b1; ind = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int c = 0; c < 12; c++) begin
            exp = {1'b1, 3'b100 >> (c / 4), 4'b1000 >> (c % 4), 1'b1};
            total++;
            if (o1 !== exp) begin
                bad++;
                $display("FAIL halt_defer c=%0d got=%b want=%b", c, o1, exp);
            end
            halt = (c == 5);
            tick();
        end
        halt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (o1 !== HALTED) begin
                bad++;
                $display("FAIL halt_defer_stopped c=%0d got=%b want=%b", c, o1, HALTED);
            end
            tick();
        end
    endtask

    task automatic test_run_halt_same();
        do_reset();
        memref = 1'b0;
        run = 1'b1; halt = 1'b1;
        tick();
        run = 1'b0; halt = 1'b0;
        total++;
        if (o1 !== HALTED) begin
            bad++;
            $display("FAIL run_halt_same got=%b want=%b", o1, HALTED);
        end
        tick();
        total++;
        if (o1 !== HALTED) begin
            bad++;
            $display("FAIL run_halt_same_idle got=%b want=%b", o1, HALTED);
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        total++;
        if (o1 !== 9'b1_100_1000_1) begin
            bad++;
            $display("FAIL run_after_halt got=%b want=%b", o1, 9'b1_100_1000_1);
        end
        // No stale halt-pending: it must run past the first boundary.
        for (int c = 0; c < 4; c++) tick();
        total++;
        if (o1 !== 9'b1_100_1000_1) begin
            bad++;
            $display("FAIL run_after_halt_cont got=%b want=%b", o1, 9'b1_100_1000_1);
        end
    endtask

    task automatic test_reset_mid_execute();
        do_reset();
        memref = 1'b1; ind = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        total++;
        if (o1 !== 9'b1_001_0010_1) begin
            bad++;
            $display("FAIL exec_t2 got=%b want=%b", o1, 9'b1_001_0010_1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (o1 !== HALTED) begin
            bad++;
            $display("FAIL reset_mid_exec got=%b want=%b", o1, HALTED);
        end
        memref = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        total++;
        if (o1 !== 9'b1_100_1000_1) begin
            bad++;
            $display("FAIL restart_after_reset got=%b want=%b", o1, 9'b1_100_1000_1);
        end
    endtask

    initial begin
        test_reset();
        test_run_p1();
        test_prescale3_defer();
        test_step();
        test_halt_in_defer();
        test_run_halt_same();
        test_reset_mid_execute();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dunc16_timing.md
Name: dunc16_timing

Overview:
- Major-state and timing-pulse generator feeding the dunc16 CPU core.
- Produces the FETCH/DEFER/EXECUTE major states, the T0..T3 minor timing phases, and a one-clock TP strobe at the end of each phase.
- Implements run/halt/single-instruction control for the board top level.
- Halts only on instruction boundaries so the core never stops mid-cycle.

Parameters:
- PRESCALE, 1, clocks per timing phase (>=1); each Tn stays asserted for PRESCALE consecutive CLK cycles.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- RUN  input  1  start request, level-sampled each clock
- HALT  input  1  halt request, level-sampled; takes effect at the next instruction boundary
- STEP  input  1  single-instruction request
- MEMREF  input  1  from core: fetched instruction references memory; sampled in FETCH T3 on TP
- IND  input  1  from core: fetched instruction is indirect; sampled with MEMREF
- FETCH  output  1  major state FETCH
- DEFER  output  1  major state DEFER
- EXECUTE  output  1  major state EXECUTE
- T0, T1, T2, T3  output  1 each  minor phase, one-hot while running, all 0 when halted
- TP  output  1  one-CLK strobe on the last clock of each phase while running
- RUNNING  output  1  machine running

Behaviour:
- Reset values (RESET high at a CLK edge, overrides every other input):
  - RUNNING=0, FETCH=1, DEFER=0, EXECUTE=0, T0..T3=0, TP=0.
  - Halt-pending flag and prescale counter cleared.
  - Applies immediately, even mid-instruction.
- Exactly one of FETCH/DEFER/EXECUTE is high at all times, including while halted.
- Prescale counter:
  - Runs 0..PRESCALE-1 while RUNNING; held at 0 when halted.
  - TP=1 when RUNNING and counter==PRESCALE-1.
  - PRESCALE=1 gives TP=1 on every running clock.
- Phase sequence: T0->T1->T2->T3->T0, advancing on the clock edge where TP=1.
- Major state is updated only on the TP edge of T3:
  - FETCH: MEMREF=0 -> FETCH; MEMREF=1 and IND=1 -> DEFER; MEMREF=1 and IND=0 -> EXECUTE.
  - DEFER -> EXECUTE.
  - EXECUTE -> FETCH.
- Instruction boundary: the T3 TP edge whose next major state is FETCH.
- Start from halt: RUN=1 or STEP=1 sampled with RUNNING=0 causes, on that edge:
  - RUNNING=1 and T0=1 visible the following cycle, with major state unchanged (FETCH after reset or a halt).
  - STEP additionally sets halt-pending, so exactly one instruction runs.
- Halt requests:
  - HALT=1 or STEP=1 while RUNNING sets halt-pending.
  - At the next instruction boundary with halt-pending=1: RUNNING=0, T0..T3=0, major state FETCH, halt-pending cleared.
  - Without halt-pending, a boundary goes to FETCH T0 and keeps running.
- HALT asserted in the same cycle as RUN or STEP while halted: HALT wins, machine stays halted, halt-pending cleared.
- RUN while RUNNING: ignored; it does not clear halt-pending.
- HALT held continuously: it is level-sampled, so the machine halts at the next boundary and stays halted until HALT falls and RUN/STEP arrives.
- MEMREF/IND are ignored except on the FETCH T3 TP edge.
- Latency figures:
  - RUN edge to first T0: 1 clock.
  - Instruction length: 4*PRESCALE clocks per major state.
  - HALT to RUNNING=0: at most 12*PRESCALE clocks (FETCH+DEFER+EXECUTE).

Test Plan:
- Reset then RUN pulse, PRESCALE=1, MEMREF=0 -> T0,T1,T2,T3 each high 1 clock; TP high every clock; FETCH stays 1; pattern repeats with period 4.
- PRESCALE=3, RUN, MEMREF=1, IND=1 at FETCH T3 -> each Tn high 3 clocks, TP only on the 3rd; FETCH 12 clocks, DEFER 12, EXECUTE 12, then FETCH.
- PRESCALE=1, STEP pulse while halted, MEMREF=1, IND=0 -> FETCH T0..T3 then EXECUTE T0..T3 (8 clocks); then RUNNING=0, T all 0, FETCH=1.
- Running, HALT pulsed during DEFER T1 -> continues through DEFER T3 and EXECUTE T0..T3; RUNNING=0 on the edge after EXECUTE T3; no T pulses afterwards.
- Halted, RUN=1 and HALT=1 same cycle -> RUNNING stays 0; a later lone RUN starts at FETCH T0 after 1 clock.
- RESET asserted during EXECUTE T2 -> next cycle RUNNING=0, FETCH=1, T all 0, TP=0; a RUN afterwards restarts at FETCH T0.
